// File: rtl/mod_range_counter.sv
// rtl/mod_range_counter.sv - modulo counter over [MIN_VAL, MAX_VAL] with up/down, checked load and carry chain
module mod_range_counter #(
  parameter int WIDTH     = 6,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 59,
  parameter int RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Enable,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             CntIn,
  input  logic             Up,
  output logic [WIDTH-1:0] COUNT,
  output logic             CarryOut,
  output logic             AtMax,
  output logic             AtMin,
  output logic             LoadErr
);

  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  logic             lo_ok;
  logic             hi_ok;
  logic             load_ok;
  logic [WIDTH-1:0] count_next;

  // Bounds that coincide with the ends of the WIDTH-bit space need no comparator.
  if (MIN_VAL == 0) begin : g_lo_free
    assign lo_ok = 1'b1;
  end else begin : g_lo_chk
    assign lo_ok = (D >= MIN_W);
  end

  if (MAX_VAL == (2 ** WIDTH) - 1) begin : g_hi_free
    assign hi_ok = 1'b1;
  end else begin : g_hi_chk
    assign hi_ok = (D <= MAX_W);
  end

  assign load_ok = lo_ok & hi_ok;

  assign AtMax = (COUNT == MAX_W);
  assign AtMin = (COUNT == MIN_W);

  assign CarryOut = Enable & CntIn & ~LD & ~Clr & (Up ? AtMax : AtMin);

  // Wrap is chosen by comparison so full-width ranges never rely on overflow.
  always_comb begin
    count_next = COUNT;
    if (Up) begin
      if (AtMax) count_next = MIN_W;
      else       count_next = COUNT + WIDTH'(1);
    end else begin
      if (AtMin) count_next = MAX_W;
      else       count_next = COUNT - WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      COUNT   <= RESET_W;
      LoadErr <= 1'b0;
    end else begin
      LoadErr <= 1'b0;
      if (Enable) begin
        if (LD) begin
          if (load_ok) COUNT   <= D;
          else         LoadErr <= 1'b1;
        end else if (CntIn) begin
          COUNT <= count_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_range_counter.sv
// tb/tb_mod_range_counter.sv - directed bench for mod_range_counter in seconds, minutes, 1..12 and day-of-week configs
module tb_mod_range_counter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // seconds (defaults)
  logic       s_clr, s_en, s_ld, s_cnt, s_up;
  logic [5:0] s_d, s_count;
  logic       s_carry, s_atmax, s_atmin, s_lerr;
  // minutes (defaults), carry-in from seconds
  logic       m_clr, m_en, m_ld, m_up;
  logic [5:0] m_d, m_count;
  logic       m_carry, m_atmax, m_atmin, m_lerr;
  // hours 1..12
  logic       h_clr, h_en, h_ld, h_cnt, h_up;
  logic [3:0] h_d, h_count;
  logic       h_carry, h_atmax, h_atmin, h_lerr;
  // day of week 0..6
  logic       w_clr, w_en, w_ld, w_cnt, w_up;
  logic [2:0] w_d, w_count;
  logic       w_carry, w_atmax, w_atmin, w_lerr;

  mod_range_counter u_sec (
    .Clk(Clk), .Clr(s_clr), .Enable(s_en), .LD(s_ld), .D(s_d), .CntIn(s_cnt), .Up(s_up),
    .COUNT(s_count), .CarryOut(s_carry), .AtMax(s_atmax), .AtMin(s_atmin), .LoadErr(s_lerr)
  );

  mod_range_counter u_min (
    .Clk(Clk), .Clr(m_clr), .Enable(m_en), .LD(m_ld), .D(m_d), .CntIn(s_carry), .Up(m_up),
    .COUNT(m_count), .CarryOut(m_carry), .AtMax(m_atmax), .AtMin(m_atmin), .LoadErr(m_lerr)
  );

  mod_range_counter #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(1)) u_hr (
    .Clk(Clk), .Clr(h_clr), .Enable(h_en), .LD(h_ld), .D(h_d), .CntIn(h_cnt), .Up(h_up),
    .COUNT(h_count), .CarryOut(h_carry), .AtMax(h_atmax), .AtMin(h_atmin), .LoadErr(h_lerr)
  );

  mod_range_counter #(.WIDTH(3), .MIN_VAL(0), .MAX_VAL(6), .RESET_VAL(0)) u_dow (
    .Clk(Clk), .Clr(w_clr), .Enable(w_en), .LD(w_ld), .D(w_d), .CntIn(w_cnt), .Up(w_up),
    .COUNT(w_count), .CarryOut(w_carry), .AtMax(w_atmax), .AtMin(w_atmin), .LoadErr(w_lerr)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    s_clr = 1'b0; s_ld = 1'b1; s_d = 6'd37;
    step();
    s_ld = 1'b0;
    checks++;
    if (s_count !== 6'd37) begin errors++; $display("FAIL reset_preload: count=%0d expected 37", s_count); end
    s_clr = 1'b1; s_ld = 1'b1; s_d = 6'd5; s_cnt = 1'b1;
    #1;
    checks++;
    if (s_carry !== 1'b0) begin errors++; $display("FAIL reset_carry: carry=%0b expected 0", s_carry); end
    step();
    s_clr = 1'b0; s_ld = 1'b0; s_cnt = 1'b0;
    checks++;
    if (s_count !== 6'd0) begin errors++; $display("FAIL reset_count: count=%0d expected 0", s_count); end
    checks++;
    if (s_lerr !== 1'b0) begin errors++; $display("FAIL reset_loaderr: loaderr=%0b expected 0", s_lerr); end
    checks++;
    if (s_atmin !== 1'b1 || s_atmax !== 1'b0) begin
      errors++; $display("FAIL reset_flags: atmin=%0b atmax=%0b expected 1 0", s_atmin, s_atmax);
    end
  endtask

  task automatic test_up_wrap_chain();
    s_ld = 1'b1; s_d = 6'd58; m_ld = 1'b1; m_d = 6'd12; s_cnt = 1'b0; s_up = 1'b1;
    step();
    s_ld = 1'b0; m_ld = 1'b0; s_cnt = 1'b1;
    #1;
    checks++;
    if (s_carry !== 1'b0) begin errors++; $display("FAIL chain_carry58: carry=%0b expected 0", s_carry); end
    step();
    checks++;
    if (s_count !== 6'd59 || m_count !== 6'd12) begin
      errors++; $display("FAIL chain_59: sec=%0d min=%0d expected 59 12", s_count, m_count);
    end
    checks++;
    if (s_carry !== 1'b1 || s_atmax !== 1'b1) begin
      errors++; $display("FAIL chain_carry59: carry=%0b atmax=%0b expected 1 1", s_carry, s_atmax);
    end
    step();
    s_cnt = 1'b0;
    checks++;
    if (s_count !== 6'd0 || m_count !== 6'd13) begin
      errors++; $display("FAIL chain_wrap: sec=%0d min=%0d expected 0 13", s_count, m_count);
    end
    checks++;
    if (s_carry !== 1'b0) begin errors++; $display("FAIL chain_carry_after: carry=%0b expected 0", s_carry); end
  endtask

  task automatic test_down_wrap();
    h_clr = 1'b1;
    step();
    h_clr = 1'b0;
    checks++;
    if (h_count !== 4'd1) begin errors++; $display("FAIL hr_reset: count=%0d expected 1", h_count); end
    h_up = 1'b0; h_cnt = 1'b1;
    #1;
    checks++;
    if (h_carry !== 1'b1) begin errors++; $display("FAIL hr_borrow: carry=%0b expected 1", h_carry); end
    step();
    checks++;
    if (h_count !== 4'd12) begin errors++; $display("FAIL hr_wrap: count=%0d expected 12", h_count); end
    checks++;
    if (h_carry !== 1'b0) begin errors++; $display("FAIL hr_borrow12: carry=%0b expected 0", h_carry); end
    step();
    checks++;
    if (h_count !== 4'd11) begin errors++; $display("FAIL hr_dec: count=%0d expected 11", h_count); end
    h_cnt = 1'b0;
  endtask

  task automatic test_load_check();
    s_ld = 1'b1; s_d = 6'd45; s_cnt = 1'b0;
    step();
    checks++;
    if (s_count !== 6'd45 || s_lerr !== 1'b0) begin
      errors++; $display("FAIL load45: count=%0d loaderr=%0b expected 45 0", s_count, s_lerr);
    end
    s_d = 6'd60;
    step();
    s_ld = 1'b0;
    checks++;
    if (s_count !== 6'd45 || s_lerr !== 1'b1) begin
      errors++; $display("FAIL load60: count=%0d loaderr=%0b expected 45 1", s_count, s_lerr);
    end
    step();
    checks++;
    if (s_count !== 6'd45 || s_lerr !== 1'b0) begin
      errors++; $display("FAIL load60_clear: count=%0d loaderr=%0b expected 45 0", s_count, s_lerr);
    end
    s_ld = 1'b1; s_d = 6'd59;
    step();
    checks++;
    if (s_count !== 6'd59 || s_lerr !== 1'b0) begin
      errors++; $display("FAIL load59: count=%0d loaderr=%0b expected 59 0", s_count, s_lerr);
    end
    h_ld = 1'b1; h_d = 4'd0;
    step();
    h_ld = 1'b0;
    checks++;
    if (h_count !== 4'd11 || h_lerr !== 1'b1) begin
      errors++; $display("FAIL hr_load0: count=%0d loaderr=%0b expected 11 1", h_count, h_lerr);
    end
  endtask

  task automatic test_load_vs_count();
    s_ld = 1'b1; s_d = 6'd10; s_cnt = 1'b1; s_up = 1'b1;
    #1;
    checks++;
    if (s_count !== 6'd59 || s_carry !== 1'b0) begin
      errors++; $display("FAIL ldcnt_carry: count=%0d carry=%0b expected 59 0", s_count, s_carry);
    end
    step();
    checks++;
    if (s_count !== 6'd10 || s_carry !== 1'b0) begin
      errors++; $display("FAIL ldcnt_result: count=%0d carry=%0b expected 10 0", s_count, s_carry);
    end
    s_ld = 1'b0; s_cnt = 1'b0;
  endtask

  task automatic test_dow_enable();
    w_clr = 1'b1;
    step();
    w_clr = 1'b0; w_cnt = 1'b1; w_up = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (w_count !== 3'(i) || w_carry !== (i == 6)) begin
        errors++; $display("FAIL dow_step%0d: count=%0d carry=%0b expected %0d %0b", i, w_count, w_carry, i, (i == 6));
      end
      step();
    end
    checks++;
    if (w_count !== 3'd0) begin errors++; $display("FAIL dow_wrap: count=%0d expected 0", w_count); end
    w_cnt = 1'b0; w_ld = 1'b1; w_d = 3'd6;
    step();
    w_en = 1'b0; w_d = 3'd3; w_cnt = 1'b1;
    #1;
    checks++;
    if (w_carry !== 1'b0) begin errors++; $display("FAIL dow_en_carry: carry=%0b expected 0", w_carry); end
    step();
    checks++;
    if (w_count !== 3'd6) begin errors++; $display("FAIL dow_en_hold: count=%0d expected 6", w_count); end
    w_d = 3'd7;
    step();
    checks++;
    if (w_count !== 3'd6 || w_lerr !== 1'b0) begin
      errors++; $display("FAIL dow_en_badload: count=%0d loaderr=%0b expected 6 0", w_count, w_lerr);
    end
    w_en = 1'b1; w_ld = 1'b0; w_cnt = 1'b0;
  endtask

  task automatic test_back_to_back();
    h_cnt = 1'b1; h_up = 1'b1;
    step();
    checks++;
    if (h_count !== 4'd12) begin errors++; $display("FAIL b2b_up: count=%0d expected 12", h_count); end
    h_up = 1'b0;
    step();
    checks++;
    if (h_count !== 4'd11) begin errors++; $display("FAIL b2b_down: count=%0d expected 11", h_count); end
    h_up = 1'b1;
    step();
    step();
    checks++;
    if (h_count !== 4'd1) begin errors++; $display("FAIL b2b_upwrap: count=%0d expected 1", h_count); end
    h_cnt = 1'b0;
  endtask

  initial begin
    s_clr = 1'b1; s_en = 1'b1; s_ld = 1'b0; s_d = '0; s_cnt = 1'b0; s_up = 1'b1;
    m_clr = 1'b1; m_en = 1'b1; m_ld = 1'b0; m_d = '0; m_up = 1'b1;
    h_clr = 1'b1; h_en = 1'b1; h_ld = 1'b0; h_d = '0; h_cnt = 1'b0; h_up = 1'b1;
    w_clr = 1'b1; w_en = 1'b1; w_ld = 1'b0; w_d = '0; w_cnt = 1'b0; w_up = 1'b1;
    step();
    m_clr = 1'b0; h_clr = 1'b0; w_clr = 1'b0;
    test_reset();
    test_up_wrap_chain();
    test_down_wrap();
    test_load_check();
    test_load_vs_count();
    test_dow_enable();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
